// File: rtl/lc3_mem_arbiter.sv
// LC-3 shared-memory arbiter: CPU vs. DMA, fixed wait states, R/ack handshake.
// Optional round-robin arbitration when LC3_ARB_FAIR_EN is defined (default: fixed CPU priority).
module lc3_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_r,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              dma_gnt,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_t     state;
    logic [3:0] cnt;
    logic       last_owner;   // 1 = DMA; also the owner of the access in flight
    logic       granted;      // no grant since reset yet -> dma_gnt stays low
    logic       pick_dma;

    always_comb begin
        pick_dma = dma_req && !cpu_req;
`ifdef LC3_ARB_FAIR_EN
        if (cpu_req && dma_req)
            pick_dma = !last_owner;
`endif
    end

    assign dma_gnt = last_owner && granted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_owner <= 1'b1;
            granted    <= 1'b0;
            cpu_r      <= 1'b0;
            dma_ack    <= 1'b0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        last_owner <= pick_dma;
                        granted    <= 1'b1;
                        mem_ce     <= 1'b1;
                        mem_we     <= pick_dma ? dma_we    : cpu_we;
                        mem_addr   <= pick_dma ? dma_addr  : cpu_addr;
                        mem_wdata  <= pick_dma ? dma_wdata : cpu_wdata;
                        cnt        <= WAIT_CNT;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Read data is captured on the last BUSY edge; writes leave rdata untouched.
                        if (!mem_we) begin
                            if (last_owner)
                                dma_rdata <= mem_rdata;
                            else
                                cpu_rdata <= mem_rdata;
                        end
                        if (last_owner)
                            dma_ack <= 1'b1;
                        else
                            cpu_r <= 1'b1;
                        mem_ce <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    cpu_r   <= 1'b0;
                    dma_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: cycle-level vector table (WAIT_STATES=2) plus reset and zero-wait sequences.
// Expectations for contended grants follow LC3_ARB_FAIR_EN when it is defined.
module tb_lc3_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_r, dma_ack, dma_gnt, mem_ce, mem_we;

    // Zero-wait instance
    logic        c0_req;
    logic [15:0] m0_rdata;
    logic [15:0] c0_rdata, d0_rdata, m0_addr, m0_wdata;
    logic        c0_r, d0_ack, d0_gnt, m0_ce, m0_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_r(cpu_r),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_gnt(dma_gnt),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(c0_req), .cpu_we(1'b0), .cpu_addr(16'h4000), .cpu_wdata(16'h0000),
        .cpu_rdata(c0_rdata), .cpu_r(c0_r),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(16'h0000),
        .dma_rdata(d0_rdata), .dma_ack(d0_ack), .dma_gnt(d0_gnt),
        .mem_ce(m0_ce), .mem_we(m0_we), .mem_addr(m0_addr), .mem_wdata(m0_wdata),
        .mem_rdata(m0_rdata)
    );

    typedef struct {
        string       name;
        logic        rst_n, creq, cwe, dreq, dwe;
        logic [15:0] caddr, cwd, daddr, dwd, mrd;
        logic [68:0] exp;   // {cpu_r, dma_ack, dma_gnt, mem_ce, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic rs, input logic cq, input logic cw,
                       input logic [15:0] ca, input logic [15:0] cd,
                       input logic dq, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                       input logic [15:0] md,
                       input logic er, input logic ea, input logic eg, input logic ec, input logic ew,
                       input logic [15:0] eaddr, input logic [15:0] ewd,
                       input logic [15:0] ecrd, input logic [15:0] edrd);
        vec_t v;
        v.name = n; v.rst_n = rs; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwd = dd; v.mrd = md;
        v.exp = {er, ea, eg, ec, ew, eaddr, ewd, ecrd, edrd};
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [68:0] got, input logic [68:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, got, want);
        end
    endtask

    function automatic logic [68:0] snap();
        return {cpu_r, dma_ack, dma_gnt, mem_ce, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata};
    endfunction

    // The two ready pulses must never coincide.
    always @(posedge clk) begin
        #1;
        checks++;
        if (cpu_r && dma_ack) begin
            errors++;
            $display("FAIL both_ready: got cpu_r=%0b dma_ack=%0b required not both 1", cpu_r, dma_ack);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_at;
        rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
        c0_req = 0; m0_rdata = 0;

        // Inputs applied at negedge; expected outputs observed 1 time unit after the next posedge.
        add("rd_grant", 1, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234, 0,0,0,1,0, 16'h3000,16'h0000,16'h0000,16'h0000);
        add("rd_busy1", 1, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234, 0,0,0,1,0, 16'h3000,16'h0000,16'h0000,16'h0000);
        add("rd_busy2", 1, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234, 0,0,0,1,0, 16'h3000,16'h0000,16'h0000,16'h0000);
        add("rd_done",  1, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234, 1,0,0,0,0, 16'h3000,16'h0000,16'h1234,16'h0000);
        add("rd_idle",  1, 0,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234, 0,0,0,0,0, 16'h3000,16'h0000,16'h1234,16'h0000);
        add("wr_grant", 1, 1,1,16'hFE06,16'h0041, 0,0,16'h0000,16'h0000, 16'hBEEF, 0,0,0,1,1, 16'hFE06,16'h0041,16'h1234,16'h0000);
        add("wr_busy1", 1, 1,1,16'h0000,16'hFFFF, 0,0,16'h0000,16'h0000, 16'hBEEF, 0,0,0,1,1, 16'hFE06,16'h0041,16'h1234,16'h0000);
        add("wr_busy2", 1, 1,0,16'h0000,16'hFFFF, 0,0,16'h0000,16'h0000, 16'hBEEF, 0,0,0,1,1, 16'hFE06,16'h0041,16'h1234,16'h0000);
        add("wr_done",  1, 0,0,16'h0000,16'hFFFF, 0,0,16'h0000,16'h0000, 16'hBEEF, 1,0,0,0,0, 16'hFE06,16'h0041,16'h1234,16'h0000);
        add("wr_idle",  1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'hBEEF, 0,0,0,0,0, 16'hFE06,16'h0041,16'h1234,16'h0000);
        add("reset",    0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,0,0,0, 16'h0000,16'h0000,16'h0000,16'h0000);
        add("both_g1",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h0000,16'h0000);
        add("both_b1a", 1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h0000,16'h0000);
        add("both_b1b", 1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h0000,16'h0000);
        add("both_d1",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 1,0,0,0,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_i1",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,0,0, 16'h0100,16'h0000,16'h5555,16'h0000);
`ifdef LC3_ARB_FAIR_EN
        add("both_g2",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,1,1,1, 16'h0200,16'hAAAA,16'h5555,16'h0000);
        add("both_b2a", 1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,1,1,1, 16'h0200,16'hAAAA,16'h5555,16'h0000);
        add("both_b2b", 1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,1,1,1, 16'h0200,16'hAAAA,16'h5555,16'h0000);
        add("both_d2",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,1,1,0,0, 16'h0200,16'hAAAA,16'h5555,16'h0000);
        add("both_i2",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,1,0,0, 16'h0200,16'hAAAA,16'h5555,16'h0000);
`else
        add("both_g2",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_b2a", 1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_b2b", 1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_d2",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 1,0,0,0,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_i2",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,0,0, 16'h0100,16'h0000,16'h5555,16'h0000);
`endif
        add("both_g3",  1, 1,0,16'h0100,16'h0000, 1,1,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_b3a", 1, 0,0,16'h0100,16'h0000, 0,0,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_b3b", 1, 0,0,16'h0100,16'h0000, 0,0,16'h0200,16'hAAAA, 16'h5555, 0,0,0,1,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_d3",  1, 0,0,16'h0100,16'h0000, 0,0,16'h0200,16'hAAAA, 16'h5555, 1,0,0,0,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("both_i3",  1, 0,0,16'h0100,16'h0000, 0,0,16'h0200,16'hAAAA, 16'h5555, 0,0,0,0,0, 16'h0100,16'h0000,16'h5555,16'h0000);
        add("dma_rd_g", 1, 0,0,16'h0100,16'h0000, 1,0,16'h0300,16'h0000, 16'h7777, 0,0,1,1,0, 16'h0300,16'h0000,16'h5555,16'h0000);
        add("dma_rd_b1",1, 0,0,16'h0100,16'h0000, 1,0,16'h0300,16'h0000, 16'h7777, 0,0,1,1,0, 16'h0300,16'h0000,16'h5555,16'h0000);
        add("dma_rd_b2",1, 0,0,16'h0100,16'h0000, 0,0,16'h0300,16'h0000, 16'h7777, 0,0,1,1,0, 16'h0300,16'h0000,16'h5555,16'h0000);
        add("dma_rd_d", 1, 0,0,16'h0100,16'h0000, 0,0,16'h0300,16'h0000, 16'h7777, 0,1,1,0,0, 16'h0300,16'h0000,16'h5555,16'h7777);
        add("dma_rd_i", 1, 0,0,16'h0100,16'h0000, 0,0,16'h0300,16'h0000, 16'h7777, 0,0,1,0,0, 16'h0300,16'h0000,16'h5555,16'h7777);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", snap(), 69'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            dma_req = vecs[i].dreq; dma_we = vecs[i].dwe; dma_addr = vecs[i].daddr; dma_wdata = vecs[i].dwd;
            mem_rdata = vecs[i].mrd;
            @(posedge clk);
            #1;
            check(vecs[i].name, snap(), vecs[i].exp);
        end

        // Reset during the second BUSY cycle of a DMA write, then re-issue.
        @(negedge clk);
        dma_req = 1; dma_we = 1; dma_addr = 16'h0400; dma_wdata = 16'h1111;
        @(posedge clk);
        #1;
        check("rst_seq_grant", {65'd0, mem_ce, mem_we, dma_gnt, cpu_r}, {65'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        check("rst_seq_addr", {37'd0, mem_addr, mem_wdata}, {37'd0, 16'h0400, 16'h1111});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", snap(), 69'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ack_at = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (dma_ack) begin
                ack_at = k;
                break;
            end
        end
        dma_req = 0;
        check("rst_reissue_latency", 69'(ack_at), 69'd4);
        check("rst_reissue_state", {36'd0, dma_gnt, mem_addr, mem_wdata}, {36'd0, 1'b1, 16'h0400, 16'h1111});
        @(posedge clk);
        #1;
        check("rst_ack_single", {67'd0, dma_ack, cpu_r}, 69'd0);

        // Zero wait states, CPU request held continuously.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            c0_req = 1'b1;
            m0_rdata = 16'h0A00 + 16'(k);
            @(posedge clk);
            #1;
            check($sformatf("ws0_cycle%0d", k), {67'd0, c0_r, m0_ce},
                  {67'd0, (k % 3 == 1) ? 1'b1 : 1'b0, (k % 3 == 0) ? 1'b1 : 1'b0});
            if (k % 3 == 1)
                check($sformatf("ws0_rdata%0d", k), 69'(c0_rdata), 69'(16'h0A00 + 16'(k)));
        end
        @(negedge clk);
        c0_req = 1'b0;
        @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
